// File: rtl/prog_fetch.sv
// -----------------------------------------------------------------------------
// prog_fetch
//
// Instruction-fetch and program-load unit for the single-cycle CPU.
// After reset the unit sits in LOAD and stores a stream of instruction words
// into its program memory. It then switches to RUN and presents mem[pc] every
// cycle, advancing the PC from the control unit's s_inc decision.
//
// State table:
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_LOAD | accepting loader words; pc held at 0, instr forced to 0
//   S_RUN  | executing; pc <= s_inc ? pc+1 : instr[PC_W-1:0]
//
// Parameters:
//   PC_W      PC / program-memory address width (depth = 2**PC_W words)
//   IW        instruction word width, must be >= PC_W + 6
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-high reset (returns to LOAD)
//   ld_valid  loader word valid
//   ld_ready  unit accepts a loader word this cycle (high in LOAD)
//   ld_data   instruction word to store
//   ld_last   final word of the program, sampled with ld_valid
//   s_inc     from control unit: 1 = pc+1, 0 = jump to instr[PC_W-1:0]
//   step      single-step advance (only with PROG_FETCH_STEP_EN)
//   run       high while in RUN
//   pc        current program counter
//   instr     mem[pc] while running, 0 while loading
//   opcode    instr[IW-1:IW-6]
//
// Build option:
//   PROG_FETCH_STEP_EN  when defined, pc advances in RUN only on edges with
//                       step=1. When undefined, step is ignored and pc
//                       advances every RUN cycle.
// -----------------------------------------------------------------------------
module prog_fetch #(
    parameter int PC_W = 10,
    parameter int IW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [IW-1:0]   ld_data,
    input  logic            ld_last,
    input  logic            s_inc,
    input  logic            step,
    output logic            run,
    output logic [PC_W-1:0] pc,
    output logic [IW-1:0]   instr,
    output logic [5:0]      opcode
);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [PC_W-1:0] ADDR_MAX = '1;

    state_t          state;
    logic [PC_W-1:0] load_addr;
    logic [IW-1:0]   mem [2**PC_W];
    logic            accept;
    logic            pc_adv;

    // Gating with reset keeps the retained program intact while reset is held.
    assign accept = ld_valid && ld_ready && !reset;

`ifdef PROG_FETCH_STEP_EN
    assign pc_adv = step;
`else
    logic unused_step;
    assign unused_step = step;
    assign pc_adv      = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_LOAD;
            ld_ready  <= 1'b1;
            run       <= 1'b0;
            pc        <= '0;
            load_addr <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (accept) begin
                        // Filling the last address forces the end of the
                        // program so load_addr never wraps onto word 0.
                        if (ld_last || load_addr == ADDR_MAX) begin
                            state    <= S_RUN;
                            ld_ready <= 1'b0;
                            run      <= 1'b1;
                        end else begin
                            load_addr <= load_addr + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (pc_adv) begin
                        pc <= s_inc ? pc + 1'b1 : instr[PC_W-1:0];
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

    // Program memory: synchronous write, not reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[load_addr] <= ld_data;
        end
    end

    always_comb begin
        instr = '0;
        if (run) begin
            instr = mem[pc];
        end
    end

    assign opcode = instr[IW-1 -: 6];

endmodule
